// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
//   Bundles the two byte-wide handshakes of the UART command parser:
//     - RX FIFO read side : fifo_empty, fifo_rd_en, fifo_dout
//     - register write bus: wr_en, wr_addr, wr_data
//   master : the parser (issues FIFO reads, drives register writes)
//   slave  : the environment (FIFO + register file)
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//   Pulls bytes out of the UART RX FIFO and parses framed write commands:
//     HEADER, ADDR, LEN, LEN payload bytes, CSUM
//   CSUM is the 8-bit XOR of ADDR, LEN and every payload byte (HEADER excluded).
//   A frame that validates is replayed as LEN single-byte register writes to
//   ADDR, ADDR+1, ... (address wraps modulo 256), one per clock.
//
// Parameters
//   HEADER          frame start byte
//   MAX_LEN         largest accepted LEN (1..255); sizes the payload buffer
//   TIMEOUT_CYCLES  inter-byte timeout in clk_in cycles (CMD_TIMEOUT_EN only)
//
// Build option
//   CMD_TIMEOUT_EN  when defined, a partial frame that stalls for
//                   TIMEOUT_CYCLES cycles is rejected; otherwise it waits forever.
//
// Ports
//   clk_in     in   clock
//   rst        in   synchronous, active-high reset
//   bus        master modport of uart_cmd_parser_if
//                fifo_empty in, fifo_rd_en out (1-cycle pulse),
//                fifo_dout in (valid the cycle after fifo_rd_en),
//                wr_en / wr_addr / wr_data out (register write bus)
//   busy       out  high in every state except S_HUNT
//   frame_ok   out  1-cycle pulse on entry to S_COMMIT
//   frame_err  out  1-cycle pulse when a frame is rejected
//   err_count  out  rejected-frame count, saturating at 8'hFF
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [7:0] HEADER         = 8'hAA,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk_in,
  input  logic                      rst,
  uart_cmd_parser_if.master         bus,
  output logic                      busy,
  output logic                      frame_ok,
  output logic                      frame_err,
  output logic [7:0]                err_count
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_COMMIT
  } state_t;

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state;
  logic             rd_en;
  logic             vld_p1;     // read outstanding: fifo_dout is valid this cycle
  logic             accept;
  logic             timeout;
  logic [7:0]       idx_r;
  logic [7:0]       idx_nxt;
  logic [IDX_W-1:0] buf_idx;
  logic             len_bad;

  logic [7:0]       addr_r;
  logic [7:0]       len_r;
  logic [7:0]       csum_r;
  logic [7:0]       pay_buf [0:MAX_LEN-1];

  logic             wr_en_r;
  logic [7:0]       wr_addr_r;
  logic [7:0]       wr_data_r;

  // Only one read may be in flight, and the FIFO is left alone while the
  // burst is replayed. Gating with rst keeps the strobe quiet during reset.
  assign rd_en   = !rst && !bus.fifo_empty && !vld_p1 && (state != S_COMMIT);
  // A byte that lands in the same cycle as a timeout is dropped.
  assign accept  = vld_p1 && !timeout;
  assign idx_nxt = idx_r + 8'd1;
  assign buf_idx = idx_r[IDX_W-1:0];
  assign len_bad = (bus.fifo_dout == 8'd0) || (bus.fifo_dout > MAX_LEN_B);

  assign bus.fifo_rd_en = rd_en;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign busy           = (state != S_HUNT);

`ifdef CMD_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic        in_frame;
  logic [31:0] to_cnt;

  assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign timeout  = in_frame && (to_cnt == TO_LAST);

  // Every entry into a frame state happens on a byte accept, so clearing on
  // accept also covers the clear-on-entry case.
  always_ff @(posedge clk_in) begin
    if (rst || !in_frame || accept || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---- p1: accepted byte captured into address / length / checksum / payload
  always_ff @(posedge clk_in) begin
    if (accept) begin
      case (state)
        S_ADDR: begin
          addr_r <= bus.fifo_dout;
          csum_r <= bus.fifo_dout;
        end
        S_LEN: begin
          len_r  <= bus.fifo_dout;
          csum_r <= csum_r ^ bus.fifo_dout;
        end
        S_DATA: begin
          pay_buf[buf_idx] <= bus.fifo_dout;
          csum_r           <= csum_r ^ bus.fifo_dout;
        end
        default: ;
      endcase
    end
  end

  // ---- p1: frame state machine, handshake and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= S_HUNT;
      vld_p1    <= 1'b0;
      idx_r     <= 8'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 8'd0;
      wr_data_r <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      vld_p1    <= rd_en;
      wr_en_r   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (timeout) begin
        frame_err <= 1'b1;
        err_count <= sat_inc(err_count);
        state     <= S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            // Anything other than HEADER is line noise; drop it quietly.
            if (accept && (bus.fifo_dout == HEADER)) begin
              state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (accept) begin
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (accept) begin
              if (len_bad) begin
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
                state     <= S_HUNT;
              end else begin
                idx_r <= 8'd0;
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (accept) begin
              idx_r <= idx_nxt;
              if (idx_nxt == len_r) begin
                state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (accept) begin
              if (bus.fifo_dout == csum_r) begin
                frame_ok <= 1'b1;
                idx_r    <= 8'd0;
                state    <= S_COMMIT;
              end else begin
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
                state     <= S_HUNT;
              end
            end
          end
          S_COMMIT: begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_r + idx_r;
            wr_data_r <= pay_buf[buf_idx];
            idx_r     <= idx_nxt;
            if (idx_nxt == len_r) begin
              state <= S_HUNT;
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//   Drives uart_cmd_parser from a byte-queue FIFO model and checks register
//   writes against an expected-write scoreboard, plus frame_ok / frame_err
//   pulse counts and err_count.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_count;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .HEADER         (8'hAA),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]  fq     [$];   // bytes waiting in the modelled RX FIFO
  logic [15:0] exp_wr [$];   // {addr, data} expected on the write bus
  logic [47:0] obs_wr [$];   // {cycle, addr, data} seen on the write bus

  int ok_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  logic       tb_empty = 1'b1;
  logic [7:0] tb_dout  = 8'h00;
  assign bus.fifo_empty = tb_empty;
  assign bus.fifo_dout  = tb_dout;

  // FIFO model: a read strobe pops a byte that appears on fifo_dout next cycle.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en && (fq.size() > 0)) tb_dout <= fq.pop_front();
  end

  // Observation side: record writes and pulses away from the active edge.
  always @(negedge clk_in) begin
    tb_empty <= (fq.size() == 0);
    if (bus.wr_en) obs_wr.push_back({32'(cyc), bus.wr_addr, bus.wr_data});
    if (frame_ok)  ok_cnt  <= ok_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (frame_ok && frame_err) both_cnt <= both_cnt + 1;
  end

  // Push n bytes, first byte in the most significant position of v.
  task automatic send(input logic [255:0] v, input int n);
    @(posedge clk_in);
    #1;
    for (int k = 0; k < n; k++) fq.push_back(v[(n-1-k)*8 +: 8]);
  endtask

  // Run until FIFO drained and the parser has been quiet for 3 cycles.
  task automatic wait_idle(input int budget, output bit expired);
    int quiet;
    quiet   = 0;
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if ((fq.size() == 0) && !busy && !bus.wr_en && !bus.fifo_rd_en) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%0b want=0", bus.fifo_rd_en); end
    checks++; if (bus.wr_en !== 1'b0)      begin errors++; $display("FAIL rst_wr_en got=%0b want=0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 8'h00)   begin errors++; $display("FAIL rst_wr_addr got=%0h want=00", bus.wr_addr); end
    checks++; if (bus.wr_data !== 8'h00)   begin errors++; $display("FAIL rst_wr_data got=%0h want=00", bus.wr_data); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy got=%0b want=0", busy); end
    checks++; if (frame_ok !== 1'b0)       begin errors++; $display("FAIL rst_frame_ok got=%0b want=0", frame_ok); end
    checks++; if (frame_err !== 1'b0)      begin errors++; $display("FAIL rst_frame_err got=%0b want=0", frame_err); end
    checks++; if (err_count !== 8'h00)     begin errors++; $display("FAIL rst_err_count got=%0h want=00", err_count); end
    rst = 1'b0;
  endtask

  // T1: AA 10 02 55 66 21 -> writes (10,55),(11,66) back to back.
  task automatic test_good_frame();
    int ok0, er0; bit to; logic [47:0] o1, o2;
    ok0 = ok_cnt; er0 = err_cnt;
    exp_wr.push_back(16'h1055);
    exp_wr.push_back(16'h1166);
    send(256'({8'hAA, 8'h10, 8'h02, 8'h55, 8'h66, 8'h21}), 6);
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL t1_idle timed out waiting for parser"); end
    checks++; if (ok_cnt - ok0 !== 1) begin errors++; $display("FAIL t1_frame_ok pulses got=%0d want=1", ok_cnt - ok0); end
    checks++; if (err_cnt - er0 !== 0) begin errors++; $display("FAIL t1_frame_err pulses got=%0d want=0", err_cnt - er0); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL t1_err_count got=%0h want=00", err_count); end
    checks++;
    if (obs_wr.size() != 2) begin
      errors++; $display("FAIL t1_wr_count got=%0d want=2", obs_wr.size());
    end else begin
      o1 = obs_wr.pop_front(); o2 = obs_wr.pop_front();
      checks++; if (o1[15:0] !== exp_wr[0]) begin errors++; $display("FAIL t1_wr0 got=%0h want=%0h", o1[15:0], exp_wr[0]); end
      checks++; if (o2[15:0] !== exp_wr[1]) begin errors++; $display("FAIL t1_wr1 got=%0h want=%0h", o2[15:0], exp_wr[1]); end
      checks++; if (o2[47:16] - o1[47:16] !== 32'd1) begin errors++; $display("FAIL t1_consecutive gap got=%0d want=1", o2[47:16] - o1[47:16]); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  // T2: bad checksum (00, correct 7B) -> one frame_err, no writes.
  task automatic test_bad_csum();
    int ok0, er0; bit to;
    ok0 = ok_cnt; er0 = err_cnt;
    send(256'({8'hAA, 8'h20, 8'h01, 8'h5A, 8'h00}), 5);
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL t2_idle timed out waiting for parser"); end
    checks++; if (err_cnt - er0 !== 1) begin errors++; $display("FAIL t2_frame_err pulses got=%0d want=1", err_cnt - er0); end
    checks++; if (ok_cnt - ok0 !== 0) begin errors++; $display("FAIL t2_frame_ok pulses got=%0d want=0", ok_cnt - ok0); end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL t2_writes got=%0d want=0", obs_wr.size()); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL t2_err_count got=%0h want=01", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy got=%0b want=0", busy); end
    obs_wr.delete();
  endtask

  // T3: LEN=0 rejected, then noise 33 skipped before a valid frame.
  task automatic test_len_zero_hunt();
    int ok0, er0; bit to; logic [47:0] o;
    ok0 = ok_cnt; er0 = err_cnt;
    exp_wr.push_back(16'h0011);
    send(256'({8'hAA, 8'h00, 8'h00, 8'h33, 8'hAA, 8'h00, 8'h01, 8'h11, 8'h10}), 9);
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL t3_idle timed out waiting for parser"); end
    checks++; if (err_cnt - er0 !== 1) begin errors++; $display("FAIL t3_frame_err pulses got=%0d want=1", err_cnt - er0); end
    checks++; if (ok_cnt - ok0 !== 1) begin errors++; $display("FAIL t3_frame_ok pulses got=%0d want=1", ok_cnt - ok0); end
    checks++; if (err_count !== 8'h02) begin errors++; $display("FAIL t3_err_count got=%0h want=02", err_count); end
    while (exp_wr.size() > 0) begin
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL t3_wr missing want=%0h", exp_wr.pop_front()); end
      else begin o = obs_wr.pop_front(); if (o[15:0] !== exp_wr[0]) begin errors++; $display("FAIL t3_wr got=%0h want=%0h", o[15:0], exp_wr[0]); end void'(exp_wr.pop_front()); end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL t3_extra_writes got=%0d want=0", obs_wr.size()); end
    obs_wr.delete();
  endtask

  // LEN boundaries: MAX_LEN+1 rejected, MAX_LEN accepted and replayed.
  task automatic test_len_bounds();
    int ok0, er0; bit to; logic [47:0] o; logic [7:0] e;
    ok0 = ok_cnt; er0 = err_cnt;
    send(256'({8'hAA, 8'h40, 8'h11}), 3);
    @(posedge clk_in); #1;
    fq.push_back(8'hAA); fq.push_back(8'h40); fq.push_back(8'h10);
    e = 8'h40 ^ 8'h10;
    for (int i = 0; i < 16; i++) begin
      fq.push_back(8'(i * 7 + 3));
      e = e ^ 8'(i * 7 + 3);
      exp_wr.push_back({8'(8'h40 + i), 8'(i * 7 + 3)});
    end
    fq.push_back(e);
    wait_idle(400, to);
    checks++; if (to) begin errors++; $display("FAIL lenb_idle timed out waiting for parser"); end
    checks++; if (err_cnt - er0 !== 1) begin errors++; $display("FAIL lenb_frame_err pulses got=%0d want=1", err_cnt - er0); end
    checks++; if (ok_cnt - ok0 !== 1) begin errors++; $display("FAIL lenb_frame_ok pulses got=%0d want=1", ok_cnt - ok0); end
    while (exp_wr.size() > 0) begin
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL lenb_wr missing want=%0h", exp_wr.pop_front()); end
      else begin o = obs_wr.pop_front(); if (o[15:0] !== exp_wr[0]) begin errors++; $display("FAIL lenb_wr got=%0h want=%0h", o[15:0], exp_wr[0]); end void'(exp_wr.pop_front()); end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL lenb_extra_writes got=%0d want=0", obs_wr.size()); end
    obs_wr.delete();
  endtask

  // T4: address wrap FE,FF,00; no FIFO reads while committing.
  task automatic test_wrap_commit();
    bit to; bit seen; logic [47:0] o;
    exp_wr.push_back(16'hFE01); exp_wr.push_back(16'hFF02); exp_wr.push_back(16'h0003);
    // trailing 00 keeps the FIFO non-empty across the commit burst
    send(256'({8'hAA, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFD, 8'h00}), 8);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk_in);
      if (frame_ok) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL t4_frame_ok not seen within 80 cycles"); end
    if (seen) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t4_rd_in_commit cycle=%0d got=%0b want=0", k, bus.fifo_rd_en); end
        @(negedge clk_in);
      end
    end
    wait_idle(200, to);
    checks++; if (to) begin errors++; $display("FAIL t4_idle timed out waiting for parser"); end
    while (exp_wr.size() > 0) begin
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL t4_wr missing want=%0h", exp_wr.pop_front()); end
      else begin o = obs_wr.pop_front(); if (o[15:0] !== exp_wr[0]) begin errors++; $display("FAIL t4_wr got=%0h want=%0h", o[15:0], exp_wr[0]); end void'(exp_wr.pop_front()); end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL t4_extra_writes got=%0d want=0", obs_wr.size()); end
    checks++; if (err_count !== 8'h03) begin errors++; $display("FAIL t4_err_count got=%0h want=03", err_count); end
    obs_wr.delete();
  endtask

  // Two frames queued together, HEADER values used as payload.
  task automatic test_back_to_back();
    int ok0, er0; bit to; logic [47:0] o;
    ok0 = ok_cnt; er0 = err_cnt;
    exp_wr.push_back(16'h05AA); exp_wr.push_back(16'h06AA); exp_wr.push_back(16'h07AA);
    send(256'({8'hAA, 8'h05, 8'h02, 8'hAA, 8'hAA, 8'h07, 8'hAA, 8'h07, 8'h01, 8'hAA, 8'hAC}), 11);
    wait_idle(300, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_idle timed out waiting for parser"); end
    checks++; if (ok_cnt - ok0 !== 2) begin errors++; $display("FAIL b2b_frame_ok pulses got=%0d want=2", ok_cnt - ok0); end
    checks++; if (err_cnt - er0 !== 0) begin errors++; $display("FAIL b2b_frame_err pulses got=%0d want=0", err_cnt - er0); end
    while (exp_wr.size() > 0) begin
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL b2b_wr missing want=%0h", exp_wr.pop_front()); end
      else begin o = obs_wr.pop_front(); if (o[15:0] !== exp_wr[0]) begin errors++; $display("FAIL b2b_wr got=%0h want=%0h", o[15:0], exp_wr[0]); end void'(exp_wr.pop_front()); end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL b2b_extra_writes got=%0d want=0", obs_wr.size()); end
    obs_wr.delete();
  endtask

  // T5: reset after the first of three commit writes.
  task automatic test_reset_mid_commit();
    bit to; bit seen; logic [47:0] o;
    exp_wr.push_back(16'h8001);
    send(256'({8'hAA, 8'h80, 8'h03, 8'h01, 8'h02, 8'h03, 8'h83}), 7);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.wr_en) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL t5_first_write not seen within 80 cycles"); end
    rst = 1'b1;
    @(negedge clk_in);
    checks++; if (bus.wr_en !== 1'b0)    begin errors++; $display("FAIL t5_wr_en got=%0b want=0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 8'h00) begin errors++; $display("FAIL t5_wr_addr got=%0h want=00", bus.wr_addr); end
    checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL t5_wr_data got=%0h want=00", bus.wr_data); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL t5_busy got=%0b want=0", busy); end
    checks++; if (err_count !== 8'h00)   begin errors++; $display("FAIL t5_err_count got=%0h want=00", err_count); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t5_rd_en got=%0b want=0", bus.fifo_rd_en); end
    rst = 1'b0;
    wait_idle(100, to);
    checks++; if (to) begin errors++; $display("FAIL t5_idle timed out waiting for parser"); end
    checks++;
    if (obs_wr.size() != 1) begin
      errors++; $display("FAIL t5_writes got=%0d want=1", obs_wr.size());
    end else begin
      o = obs_wr.pop_front();
      checks++; if (o[15:0] !== exp_wr[0]) begin errors++; $display("FAIL t5_wr got=%0h want=%0h", o[15:0], exp_wr[0]); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  // err_count saturation after 260 rejected frames.
  task automatic test_err_saturate();
    int er0; bit to;
    er0 = err_cnt;
    for (int i = 0; i < 260; i++) send(256'({8'hAA, 8'h00, 8'h00}), 3);
    wait_idle(4000, to);
    checks++; if (to) begin errors++; $display("FAIL sat_idle timed out waiting for parser"); end
    checks++; if (err_cnt - er0 !== 260) begin errors++; $display("FAIL sat_pulses got=%0d want=260", err_cnt - er0); end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_err_count got=%0h want=ff", err_count); end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL sat_writes got=%0d want=0", obs_wr.size()); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ok_err_overlap got=%0d want=0", both_cnt); end
    obs_wr.delete();
  endtask

`ifdef CMD_TIMEOUT_EN
  // T6: AA 10 then silence; frame_err arrives after TIMEOUT_CYCLES.
  task automatic test_timeout();
    int er0; int b_at; int e_at; bit to;
    er0 = err_cnt; b_at = -1; e_at = -1;
    send(256'({8'hAA, 8'h10}), 2);
    for (int i = 0; i < 120 && e_at < 0; i++) begin
      @(negedge clk_in);
      if (busy && b_at < 0) b_at = i;
      if (frame_err) e_at = i;
    end
    checks++; if (e_at < 0) begin errors++; $display("FAIL t6_frame_err not seen within 120 cycles"); end
    checks++; if (b_at < 0 || (e_at - b_at) < 50 || (e_at - b_at) > 54) begin errors++; $display("FAIL t6_delay got=%0d want=50..54", e_at - b_at); end
    wait_idle(100, to);
    checks++; if (to) begin errors++; $display("FAIL t6_idle timed out waiting for parser"); end
    checks++; if (err_cnt - er0 !== 1) begin errors++; $display("FAIL t6_pulses got=%0d want=1", err_cnt - er0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got=%0b want=0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_zero_hunt();
    test_len_bounds();
    test_wrap_commit();
    test_back_to_back();
    test_reset_mid_commit();
    test_err_saturate();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
